// File: rtl/hand_track_pkg.sv
// Shared types, widths and default tuning constants for the player-2 hand tracker.
package hand_track_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_DIV_X,
      S_DIV_Y,
      S_FILTER,
      S_LOST
   } state_t;

   localparam int SUM_X_W    = 31;
   localparam int SUM_Y_W    = 30;
   localparam int CNT_W      = 20;
   localparam int DIV_CYCLES = 31;
   localparam int QX_W       = 11;
   localparam int QY_W       = 10;

   localparam int MIN_PIXELS_DEF  = 64;
   localparam int CLOSED_AREA_DEF = 2000;
   localparam int DEBOUNCE_DEF    = 3;
   localparam int LOST_FRAMES_DEF = 3;
   localparam int ALPHA_SHIFT_DEF = 2;
   localparam int HALF_W_DEF      = 32;

   // Exponential smoothing step; the shift is arithmetic, so negative moves round toward -inf.
   function automatic logic [10:0] smooth(input logic [10:0] c, input logic [10:0] m,
                                          input logic first, input int shift);
      logic signed [11:0] d;
      d = $signed({1'b0, m}) - $signed({1'b0, c});
      d = d >>> shift;
      return first ? m : c + d[10:0];
   endfunction

   function automatic logic [15:0] top_left(input logic [10:0] c, input int half);
      return (int'(c) > half) ? 16'(int'(c) - half) : 16'd0;
   endfunction

endpackage

// File: rtl/seq_divider.sv
// Restoring divider, one quotient bit per cycle. The first bit is resolved on the start edge,
// so done rises DIV_CYCLES-1 cycles after start and the quotient holds until the next start.
module seq_divider
   import hand_track_pkg::*;
(
   input  logic               clk,
   input  logic               reset_n,
   input  logic               start,
   input  logic [SUM_X_W-1:0] dividend,
   input  logic [CNT_W-1:0]   divisor,
   output logic               done,
   output logic [QX_W-1:0]    quotient
);

   logic [CNT_W-1:0]   rem, src_rem, nxt_rem, dvs, src_dvs;
   logic [SUM_X_W-1:0] quo, src_quo, nxt_quo;
   logic [CNT_W:0]     trial;
   logic               ge;
   logic [4:0]         steps;

   always_comb begin
      src_rem = start ? '0 : rem;
      src_quo = start ? dividend : quo;
      src_dvs = start ? divisor : dvs;
      trial   = {src_rem, src_quo[SUM_X_W-1]};
      ge      = (trial >= {1'b0, src_dvs});
      nxt_rem = ge ? (trial[CNT_W-1:0] - src_dvs) : trial[CNT_W-1:0];
      nxt_quo = {src_quo[SUM_X_W-2:0], ge};
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rem   <= '0;
         quo   <= '0;
         dvs   <= '0;
         steps <= '0;
      end else if (start) begin
         rem   <= nxt_rem;
         quo   <= nxt_quo;
         dvs   <= divisor;
         steps <= 5'(DIV_CYCLES - 1);
      end else if (steps != 5'd0) begin
         rem   <= nxt_rem;
         quo   <= nxt_quo;
         steps <= steps - 5'd1;
      end
   end

   assign done     = (steps == 5'd0);
   assign quotient = quo[QX_W-1:0];

endmodule

// File: rtl/hand_tracker_p2.sv
// Per-frame hand centroid/area tracker feeding the player-2 sprite draw stage.
// state    | meaning
// IDLE     | accumulating hits, waiting for frame_start
// DIV_X    | dividing x sum by hit count
// DIV_Y    | dividing y sum by hit count
// FILTER   | smoothing, debounce, output refresh
// LOST     | frame too small, advance lost counter
module hand_tracker_p2
   import hand_track_pkg::*;
#(
   parameter int MIN_PIXELS  = MIN_PIXELS_DEF,
   parameter int CLOSED_AREA = CLOSED_AREA_DEF,
   parameter int DEBOUNCE    = DEBOUNCE_DEF,
   parameter int LOST_FRAMES = LOST_FRAMES_DEF,
   parameter int ALPHA_SHIFT = ALPHA_SHIFT_DEF,
   parameter int HALF_W      = HALF_W_DEF
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        frame_start,
   input  logic        det_valid,
   input  logic [10:0] det_x,
   input  logic [9:0]  det_y,
   output logic [15:0] x,
   output logic [15:0] y,
   output logic        closed,
   output logic        present,
   output logic        update
);

   state_t             state, state_nxt;
   logic [SUM_X_W-1:0] sum_x, div_dividend;
   logic [SUM_Y_W-1:0] sum_y, snap_y;
   logic [CNT_W-1:0]   cnt, snap_cnt, div_divisor;
   logic               div_start, div_done;
   logic [QX_W-1:0]    div_q, mx_q, my, cx, cy, cx_nxt, cy_nxt;
   logic               fix, first, vote;
   logic [3:0]         lost_cnt, lost_nxt, agree;

   // The x sum is captured by the divider itself on the frame edge; only y and cnt need a snapshot.
   seq_divider u_div (
      .clk      (clk),
      .reset_n  (reset_n),
      .start    (div_start),
      .dividend (div_dividend),
      .divisor  (div_divisor),
      .done     (div_done),
      .quotient (div_q)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= S_IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt    = state;
      div_start    = 1'b0;
      div_dividend = sum_x;
      div_divisor  = cnt;
      case (state)
         S_IDLE: begin
            if (frame_start) begin
               if (cnt >= CNT_W'(MIN_PIXELS)) begin
                  state_nxt = S_DIV_X;
                  div_start = 1'b1;
               end else begin
                  state_nxt = S_LOST;
               end
            end
         end
         S_DIV_X: begin
            if (div_done) begin
               state_nxt    = S_DIV_Y;
               div_start    = 1'b1;
               div_dividend = {1'b0, snap_y};
               div_divisor  = snap_cnt;
            end
         end
         S_DIV_Y:  if (div_done) state_nxt = S_FILTER;
         S_FILTER: state_nxt = S_IDLE;
         S_LOST:   state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      my       = {1'b0, div_q[QY_W-1:0]};
      first    = !fix || !present;
      cx_nxt   = smooth(cx, mx_q, first, ALPHA_SHIFT);
      cy_nxt   = smooth(cy, my, first, ALPHA_SHIFT);
      vote     = (snap_cnt < CNT_W'(CLOSED_AREA));
      lost_nxt = (lost_cnt >= 4'(LOST_FRAMES)) ? lost_cnt : lost_cnt + 4'd1;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sum_x    <= '0;
         sum_y    <= '0;
         cnt      <= '0;
         snap_y   <= '0;
         snap_cnt <= '0;
         mx_q     <= '0;
         cx       <= '0;
         cy       <= '0;
         fix      <= 1'b0;
         lost_cnt <= '0;
         agree    <= '0;
         x        <= '0;
         y        <= '0;
         closed   <= 1'b0;
         present  <= 1'b0;
         update   <= 1'b0;
      end else begin
         update <= 1'b0;
         // A hit on the frame_start cycle already belongs to the new frame.
         if (frame_start) begin
            sum_x <= det_valid ? SUM_X_W'(det_x) : '0;
            sum_y <= det_valid ? SUM_Y_W'(det_y) : '0;
            cnt   <= det_valid ? CNT_W'(1) : '0;
         end else if (det_valid) begin
            sum_x <= sum_x + SUM_X_W'(det_x);
            sum_y <= sum_y + SUM_Y_W'(det_y);
            cnt   <= cnt + CNT_W'(1);
         end
         if (state == S_IDLE && frame_start) begin
            snap_y   <= sum_y;
            snap_cnt <= cnt;
         end
         if (state == S_DIV_X && div_done) mx_q <= div_q;
         if (state == S_FILTER) begin
            cx       <= cx_nxt;
            cy       <= cy_nxt;
            fix      <= 1'b1;
            x        <= top_left(cx_nxt, HALF_W);
            y        <= top_left(cy_nxt, HALF_W);
            present  <= 1'b1;
            lost_cnt <= '0;
            update   <= 1'b1;
            if (vote != closed) begin
               if (agree + 4'd1 == 4'(DEBOUNCE)) begin
                  closed <= ~closed;
                  agree  <= '0;
               end else begin
                  agree <= agree + 4'd1;
               end
            end else begin
               agree <= '0;
            end
         end
         if (state == S_LOST) begin
            lost_cnt <= lost_nxt;
            if (lost_nxt == 4'(LOST_FRAMES)) present <= 1'b0;
            update <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_hand_tracker_p2.sv
// Directed bench for hand_tracker_p2 with a reference-model scoreboard checked on every update.
module tb_hand_tracker_p2;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        frame_start = 1'b0;
   logic        det_valid = 1'b0;
   logic [10:0] det_x = '0;
   logic [9:0]  det_y = '0;
   logic [15:0] x, y;
   logic        closed, present, update;

   hand_tracker_p2 dut (
      .clk(clk), .reset_n(reset_n), .frame_start(frame_start), .det_valid(det_valid),
      .det_x(det_x), .det_y(det_y), .x(x), .y(y), .closed(closed), .present(present),
      .update(update)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int          cyc;
      logic [15:0] x;
      logic [15:0] y;
      logic        closed;
      logic        present;
   } exp_t;
   exp_t q[$];

   int errors = 0;
   int checks = 0;

   int          m_cx, m_cy, m_agree, m_lost, busy_end;
   bit          m_fix, m_present, m_closed;
   logic [15:0] m_x, m_y;
   longint      sx, sy;
   int          sc;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   always @(negedge clk) begin
      if (update === 1'b1) begin
         check("update_expected", 32'(q.size() > 0), 32'd1);
         if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            check("update_cycle", cyc, e.cyc);
            check("x", 32'(x), 32'(e.x));
            check("y", 32'(y), 32'(e.y));
            check("closed", 32'(closed), 32'(e.closed));
            check("present", 32'(present), 32'(e.present));
         end
      end
   end

   task automatic model_reset();
      m_cx = 0; m_cy = 0; m_agree = 0; m_lost = 0; busy_end = -1;
      m_fix = 0; m_present = 0; m_closed = 0; m_x = '0; m_y = '0;
      sx = 0; sy = 0; sc = 0;
      q.delete();
   endtask

   task automatic model_frame(input int k);
      exp_t e;
      int   lat;
      if (sc >= 64) begin
         int  mx, my;
         bit  vote;
         mx = int'(sx / sc) % 2048;
         my = int'(sy / sc) % 1024;
         if (!m_fix || !m_present) begin
            m_cx = mx; m_cy = my;
         end else begin
            m_cx = m_cx + ((mx - m_cx) >>> 2);
            m_cy = m_cy + ((my - m_cy) >>> 2);
         end
         m_fix = 1; m_present = 1; m_lost = 0;
         m_x = (m_cx > 32) ? 16'(m_cx - 32) : 16'd0;
         m_y = (m_cy > 32) ? 16'(m_cy - 32) : 16'd0;
         vote = (sc < 2000);
         if (vote != m_closed) begin
            m_agree++;
            if (m_agree == 3) begin m_closed = !m_closed; m_agree = 0; end
         end else begin
            m_agree = 0;
         end
         lat = 63;
      end else begin
         if (m_lost < 3) m_lost++;
         if (m_lost == 3) m_present = 0;
         lat = 1;
      end
      e.cyc = k + lat; e.x = m_x; e.y = m_y; e.closed = m_closed; e.present = m_present;
      q.push_back(e);
      busy_end = k + lat;
   endtask

   task automatic hits(input int n, input int hx, input int hy);
      for (int i = 0; i < n; i++) begin
         det_valid = 1'b1; det_x = 11'(hx); det_y = 10'(hy);
         @(posedge clk); #1;
         sx += hx; sy += hy; sc++;
      end
      det_valid = 1'b0;
   endtask

   task automatic pulse_frame();
      int k;
      det_valid = 1'b0;
      frame_start = 1'b1;
      @(posedge clk); #1;
      k = cyc;
      frame_start = 1'b0;
      if (k > busy_end) model_frame(k);
      sx = 0; sy = 0; sc = 0;
   endtask

   task automatic drain();
      int t = 0;
      while (q.size() > 0 && t < 200) begin
         @(posedge clk); t++;
      end
      #1;
      check("drain_pending", q.size(), 0);
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic frame(input int n, input int hx, input int hy);
      hits(n, hx, hy);
      pulse_frame();
      drain();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      model_reset();
      repeat (5) @(posedge clk);
      #1;
      check("rst_x", 32'(x), 0);
      check("rst_y", 32'(y), 0);
      check("rst_closed", 32'(closed), 0);
      check("rst_present", 32'(present), 0);
      check("rst_update", 32'(update), 0);
      reset_n = 1'b1;
      repeat (10) @(posedge clk);
      #1;

      // first fix and smoothing
      frame(100, 200, 300);
      check("t2_x", 32'(x), 168);
      check("t2_y", 32'(y), 268);
      check("t2_present", 32'(present), 1);
      check("t2_closed", 32'(closed), 0);
      frame(100, 400, 300);
      check("t3_x", 32'(x), 218);
      check("t3_y", 32'(y), 268);

      // lost frames below MIN_PIXELS, then a snap to the new centroid
      for (int i = 0; i < 3; i++) frame(10, 50, 50);
      check("t4_present", 32'(present), 0);
      frame(100, 600, 400);
      check("t4_snap_x", 32'(x), 568);

      // debounce; 2000 hits is exactly the open boundary, 1999 votes closed
      for (int i = 0; i < 3; i++) frame(2000, 500, 400);
      check("t5_open", 32'(closed), 0);
      frame(500, 500, 400);
      frame(500, 500, 400);
      frame(5000, 500, 400);
      frame(1999, 500, 400);
      frame(500, 500, 400);
      check("t5_still_open", 32'(closed), 0);
      frame(500, 500, 400);
      check("t5_closed", 32'(closed), 1);

      // reset 20 cycles into DIV_X aborts the division
      hits(100, 300, 300);
      pulse_frame();
      repeat (20) @(posedge clk);
      #1;
      reset_n = 1'b0;
      #1;
      check("abort_x", 32'(x), 0);
      check("abort_y", 32'(y), 0);
      check("abort_closed", 32'(closed), 0);
      check("abort_present", 32'(present), 0);
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      reset_n = 1'b1;
      repeat (80) @(posedge clk);
      #1;

      // frame_start during DIV_Y is dropped; in-flight update unaffected
      hits(100, 300, 200);
      pulse_frame();
      repeat (40) @(posedge clk);
      #1;
      hits(5, 700, 700);
      pulse_frame();
      drain();
      frame(100, 320, 200);
      check("drop_x", 32'(x), 273);

      // truncating division and floor rounding of negative moves
      hits(50, 100, 50);
      frame(50, 103, 51);
      check("trunc_x", 32'(x), 222);
      check("trunc_y", 32'(y), 130);

      // empty frames drop presence, then a clamped first fix
      for (int i = 0; i < 3; i++) begin
         pulse_frame();
         drain();
      end
      frame(100, 10, 5);
      check("clamp_x", 32'(x), 0);
      check("clamp_y", 32'(y), 0);
      check("clamp_present", 32'(present), 1);

      check("queue_empty", q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
